// File: rtl/vga_sync_core.sv
// vga_sync_core: VGA timing generator with a small register slot and output colour mux.
//
// Optional feature: define VGA_SYNC_TESTPAT_EN to build the 8-bar test-pattern generator
// (ctrl bit1). Without it ctrl bit1 is not stored and no generator logic exists.
//
// Ports:
//   clk, reset         system clock, asynchronous active-high reset
//   cs, write          register write strobe (write happens when cs & write)
//   addr[13:0]         register address; addr[1:0]: 0 = ctrl, 1 = blank_color
//   wr_data[31:0]      write data
//   x, y               current pixel coordinates (straight from the counters)
//   line_start         one-clk pulse coinciding with h wrapping to 0
//   frame_start        one-clk pulse coinciding with (h,v) wrapping to (0,0)
//   si_rgb             colour returned by the sprite/overlay chain, PIPE_DLY clk after x/y
//   hsync, vsync       active-low sync, PIPE_DLY+1 clk after x/y
//   rgb                final registered pixel colour, PIPE_DLY+1 clk after x/y
module vga_sync_core #(
  parameter int unsigned CD       = 12,
  parameter int unsigned H_DISP   = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_DISP   = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned DIV      = 4,
  parameter int unsigned PIPE_DLY = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cs,
  input  logic          write,
  input  logic [13:0]   addr,
  input  logic [31:0]   wr_data,
  output logic [10:0]   x,
  output logic [10:0]   y,
  output logic          line_start,
  output logic          frame_start,
  input  logic [CD-1:0] si_rgb,
  output logic          hsync,
  output logic          vsync,
  output logic [CD-1:0] rgb
);

  localparam int unsigned H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;
  localparam int unsigned PW      = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [PW-1:0] PS_LAST  = PW'(DIV - 1);
  localparam logic [10:0]   H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0]   V_LAST   = 11'(V_TOTAL - 1);
  localparam logic [10:0]   H_DISP_C = 11'(H_DISP);
  localparam logic [10:0]   V_DISP_C = 11'(V_DISP);
  localparam logic [10:0]   HS_BEG   = 11'(H_DISP + H_FP);
  localparam logic [10:0]   HS_END   = 11'(H_DISP + H_FP + H_SYNC - 1);
  localparam logic [10:0]   VS_BEG   = 11'(V_DISP + V_FP);
  localparam logic [10:0]   VS_END   = 11'(V_DISP + V_FP + V_SYNC - 1);

  logic [PW-1:0] ps;
  logic          tick;
  logic [10:0]   h_cnt;
  logic [10:0]   v_cnt;
  logic          video_on_c;
  logic          hsync_raw_c;
  logic          vsync_raw_c;
  logic [PIPE_DLY-1:0] hs_dly;
  logic [PIPE_DLY-1:0] vs_dly;
  logic [PIPE_DLY-1:0] vid_dly;
  logic          wr_en;
  logic          force_blank;
  logic [CD-1:0] blank_color;
  logic [CD-1:0] pix_c;
  logic          unused_bits;

  assign tick  = (ps == PS_LAST);
  assign wr_en = cs & write;
  assign x     = h_cnt;
  assign y     = v_cnt;

  // Pixel-rate prescaler
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     ps <= '0;
    else if (tick) ps <= '0;
    else           ps <= ps + PW'(1);
  end

  // Raster counters; the pulses are registered so they coincide with the wrapped counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (tick) begin
        if (h_cnt == H_LAST) begin
          h_cnt      <= '0;
          line_start <= 1'b1;
          if (v_cnt == V_LAST) begin
            v_cnt       <= '0;
            frame_start <= 1'b1;
          end else begin
            v_cnt <= v_cnt + 11'd1;
          end
        end else begin
          h_cnt <= h_cnt + 11'd1;
        end
      end
    end
  end

  assign video_on_c  = (h_cnt < H_DISP_C) && (v_cnt < V_DISP_C);
  assign hsync_raw_c = !((h_cnt >= HS_BEG) && (h_cnt <= HS_END));
  assign vsync_raw_c = !((v_cnt >= VS_BEG) && (v_cnt <= VS_END));

  // Delay lines matching the sprite chain latency; reset to inactive values
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hs_dly  <= '1;
      vs_dly  <= '1;
      vid_dly <= '0;
    end else begin
      hs_dly[0]  <= hsync_raw_c;
      vs_dly[0]  <= vsync_raw_c;
      vid_dly[0] <= video_on_c;
      for (int i = 1; i < int'(PIPE_DLY); i++) begin
        hs_dly[i]  <= hs_dly[i-1];
        vs_dly[i]  <= vs_dly[i-1];
        vid_dly[i] <= vid_dly[i-1];
      end
    end
  end

  // ctrl bit0 and blank colour registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      force_blank <= 1'b0;
      blank_color <= '0;
    end else if (wr_en) begin
      case (addr[1:0])
        2'd0:    force_blank <= wr_data[0];
        2'd1:    blank_color <= wr_data[CD-1:0];
        default: ;
      endcase
    end
  end

`ifdef VGA_SYNC_TESTPAT_EN
  localparam int unsigned BAR_W = H_DISP / 8;
  localparam int unsigned CW    = CD / 3;

  logic          testpat_en;
  logic [2:0]    bar_idx_c;
  logic [CD-1:0] bar_c;
  logic [CD-1:0] bar_dly [PIPE_DLY];

  // Bar colour from per-channel on/off pattern, left to right
  function automatic logic [CD-1:0] bar_color(input logic [2:0] idx);
    logic [2:0] on;
    case (idx)
      3'd0:    on = 3'b111;
      3'd1:    on = 3'b110;
      3'd2:    on = 3'b011;
      3'd3:    on = 3'b010;
      3'd4:    on = 3'b101;
      3'd5:    on = 3'b100;
      3'd6:    on = 3'b001;
      default: on = 3'b000;
    endcase
    return CD'({{CW{on[2]}}, {CW{on[1]}}, {CW{on[0]}}});
  endfunction

  // Index is only meaningful inside the active area; blanking masks the rest
  assign bar_idx_c = 3'(h_cnt / 11'(BAR_W));
  assign bar_c     = bar_color(bar_idx_c);

  // ctrl bit1
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                         testpat_en <= 1'b0;
    else if (wr_en && addr[1:0] == 2'd0) testpat_en <= wr_data[1];
  end

  // Bar colour delayed to line up with si_rgb
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(PIPE_DLY); i++) bar_dly[i] <= '0;
    end else begin
      bar_dly[0] <= bar_c;
      for (int i = 1; i < int'(PIPE_DLY); i++) bar_dly[i] <= bar_dly[i-1];
    end
  end

  always_comb begin
    pix_c = si_rgb;
    if (testpat_en) pix_c = bar_dly[PIPE_DLY-1];
  end

  assign unused_bits = ^{addr[13:2], wr_data[31:CD]};
`else
  always_comb begin
    pix_c = si_rgb;
  end

  assign unused_bits = ^{addr[13:2], wr_data[31:CD], wr_data[1]};
`endif

  // Output register: blanking, then forced colour, then pattern/stream
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hsync <= 1'b1;
      vsync <= 1'b1;
      rgb   <= '0;
    end else begin
      hsync <= hs_dly[PIPE_DLY-1];
      vsync <= vs_dly[PIPE_DLY-1];
      if (!vid_dly[PIPE_DLY-1]) rgb <= '0;
      else if (force_blank)     rgb <= blank_color;
      else                      rgb <= pix_c;
    end
  end

endmodule

// File: doc/vga_sync_core.md
VGA_SYNC_CORE -- requirements
Module: vga_sync_core

Interface
REQ-001 Parameter CD, 12, colour depth in bits.
REQ-002 Parameters H_DISP/H_FP/H_SYNC/H_BP, defaults 640/16/96/48, horizontal timing in pixels.
REQ-003 Parameters V_DISP/V_FP/V_SYNC/V_BP, defaults 480/10/2/33, vertical timing in lines.
REQ-004 Parameter DIV, 4, clk cycles per pixel.
REQ-005 Parameter PIPE_DLY, 2, clk cycles of latency from x/y out to si_rgb in.
REQ-006 clk  input  1  system clock; the block has one clock.
REQ-007 reset  input  1  reset, asynchronous and active-high.
REQ-008 cs  input  1  video-slot select.
REQ-009 write  input  1  write strobe.
REQ-010 addr  input  14  register address; only addr[1:0] is decoded.
REQ-011 wr_data  input  32  write data.
REQ-012 x, y  output  11 each  current pixel coordinates, driven straight from the counters.
REQ-013 line_start, frame_start  output  1 each  single-clk pulses.
REQ-014 si_rgb  input  CD  returned stream from the sprite/overlay chain.
REQ-015 hsync, vsync  output  1 each  active-low sync.
REQ-016 rgb  output  CD  final registered pixel colour.

Function
REQ-017 Prescaler counts 0..DIV-1; tick is high for one clk when it equals DIV-1; it then wraps to 0.
REQ-018 h_cnt advances on tick over 0..H_TOTAL-1 (H_TOTAL = sum of the H parameters); at H_TOTAL-1 it wraps to 0 and v_cnt increments.
REQ-019 v_cnt covers 0..V_TOTAL-1; when it increments at V_TOTAL-1 it wraps to 0.
REQ-020 line_start is high on a tick that wraps h_cnt to 0; frame_start is high on a tick that wraps both counters to (0,0).
REQ-021 video_on = (h_cnt<H_DISP)&&(v_cnt<V_DISP).
REQ-022 hsync_raw = 0 iff h_cnt is in [H_DISP+H_FP, H_DISP+H_FP+H_SYNC-1].
REQ-023 vsync_raw = 0 iff v_cnt is in [V_DISP+V_FP, V_DISP+V_FP+V_SYNC-1].
REQ-024 hsync_raw, vsync_raw and video_on pass through a PIPE_DLY-clk shift register and then the output register.
REQ-025 Register writes occur when wr_en = cs&write.
REQ-026 addr[1:0]=0 writes ctrl, bit0 force_blank and bit1 testpat_en.
REQ-027 addr[1:0]=1 writes blank_color = wr_data[CD-1:0].
REQ-028 Other addresses are ignored.
REQ-029 Output mux, registered, priority order: delayed video_on=0 -> 0; else force_blank -> blank_color; else testpat_en -> delayed bar colour; else si_rgb.
REQ-030 Latency: hsync, vsync and rgb lag the x/y change by exactly PIPE_DLY+1 clk.
REQ-031 A register write takes effect on the next clk edge, including one that coincides with frame_start.

Reset
REQ-032 Reset clears the prescaler, h_cnt, v_cnt and ctrl, and sets blank_color = 0.
REQ-033 Reset fills the delay lines with inactive values (sync=1, video_on=0).
REQ-034 During reset the outputs are x=0, y=0, hsync=1, vsync=1, rgb=0, and both pulses are 0.
REQ-035 Reset asserted mid-frame aborts immediately; after release counting restarts from (0,0) with no frame_start until the first full frame wraps.

Configuration
REQ-036 Macro VGA_SYNC_TESTPAT_EN, when defined, adds the bar generator: 8 vertical bars of width H_DISP/8.
REQ-037 Bar colours, left to right: FFF, FF0, 0FF, 0F0, F0F, F00, 00F, 000.
REQ-038 The bar colour is delayed PIPE_DLY clk to stay aligned with si_rgb.
REQ-039 Without the macro, ctrl bit1 is not stored, reads as 0 and has no effect, and no generator logic exists.

Verification
REQ-040 Free run from reset -> line_start period 3200 clk; frame_start period 1,680,000 clk; first frame_start at clk 1,680,000.
REQ-041 Free run -> hsync low for exactly 384 clk per line; vsync low for exactly 2 lines (6400 clk).
REQ-042 si_rgb=ABC at x<640, y<480 -> rgb=ABC exactly 3 clk after x/y change; rgb=000 in blanking.
REQ-043 Write addr=1 data=0F0, then addr=0 data=1 -> rgb=0F0 throughout active video from the next clk, 000 in blanking.
REQ-044 Macro defined, write addr=0 data=2 -> rgb=FFF for x 0..79 and 000 for x 560..639; macro undefined -> rgb follows si_rgb.
REQ-045 Assert reset at x=300, y=200 for 5 clk -> outputs take reset values within the same clk; after release x=0, y=0 and counting resumes.
